// File: rtl/hex_mul_pkg.sv
// Shared constants for the hex multiplier: widths, datapath state codes
// and per-step shift selects used by the controller and accumulator.
package hex_mul_pkg;

  localparam int unsigned OP_W  = 8;
  localparam int unsigned NIB_W = OP_W / 2;
  localparam int unsigned ACC_W = 2 * OP_W;

  // Codes are visible on the state port and decoded by the datapath mux.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_COMPUTE_1 = 3'b001,
    ST_COMPUTE_2 = 3'b010,
    ST_COMPUTE_3 = 3'b011,
    ST_COMPUTE_4 = 3'b100,
    ST_DONE      = 3'b101
  } state_e;

  typedef enum logic [1:0] {
    SH_0 = 2'd0,
    SH_4 = 2'd1,
    SH_8 = 2'd2
  } shift_sel_e;

  localparam shift_sel_e SHIFT_C1 = SH_0;
  localparam shift_sel_e SHIFT_C2 = SH_4;
  localparam shift_sel_e SHIFT_C3 = SH_4;
  localparam shift_sel_e SHIFT_C4 = SH_8;

endpackage

// File: rtl/hex_mul_acc.sv
// 16-bit shift-accumulate register: acc <= acc + (zero-extended pp << shift).
// Clear has priority over add; the largest 8x8 product never carries out.
module hex_mul_acc
  import hex_mul_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             add_en,
  input  shift_sel_e       shift_sel,
  input  logic [2*NIB_W-1:0] pp,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] pp_ext;
  logic [ACC_W-1:0] addend;

  always_comb begin
    pp_ext = {{(ACC_W - 2*NIB_W){1'b0}}, pp};
    addend = '0;
    case (shift_sel)
      SH_0:    addend = pp_ext;
      SH_4:    addend = pp_ext << 4;
      SH_8:    addend = pp_ext << 8;
      default: addend = '0;
    endcase
  end

  // NOTE: sequential state is written with <= so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + addend;
    end
  end

endmodule

// File: rtl/hex_mul_seq_ctrl.sv
// Sequencing controller for the hex multiplier: operand handshake, four
// nibble-product steps, result handshake. Optional HEX_MUL_ZERO_SKIP_EN
// sends zero-operand transactions straight from IDLE to DONE.
module hex_mul_seq_ctrl #(
  parameter  int unsigned OP_W  = 8,
  localparam int unsigned NIB_W = OP_W / 2,
  localparam int unsigned ACC_W = 2 * OP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_a,
  input  logic [OP_W-1:0]    in_b,
  input  logic               abort,
  output logic [2:0]         state,
  output logic               mux_en,
  output logic [NIB_W-1:0]   nib_a,
  output logic [NIB_W-1:0]   nib_b,
  input  logic [2*NIB_W-1:0] pp_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ACC_W-1:0]   result
);

  import hex_mul_pkg::*;

  if (OP_W != 8) begin : g_op_w_check
    $error("hex_mul_seq_ctrl: only OP_W = 8 is supported");
  end

  state_e           state_q;
  state_e           state_d;
  logic [OP_W-1:0]  a_q;
  logic [OP_W-1:0]  b_q;
  logic             accept;
  logic             busy;
  logic             zero_op;
  logic             acc_clr;
  shift_sel_e       shift_sel;
  logic [ACC_W-1:0] acc;

  assign accept = in_valid & in_ready;
  assign busy   = (state_q != ST_IDLE);
  assign acc_clr = accept | (abort & busy);

`ifdef HEX_MUL_ZERO_SKIP_EN
  assign zero_op = (in_a == '0) || (in_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= in_a;
      b_q <= in_b;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (accept) state_d = zero_op ? ST_DONE : ST_COMPUTE_1;
      ST_COMPUTE_1: state_d = ST_COMPUTE_2;
      ST_COMPUTE_2: state_d = ST_COMPUTE_3;
      ST_COMPUTE_3: state_d = ST_COMPUTE_4;
      ST_COMPUTE_4: state_d = ST_DONE;
      ST_DONE:      if (res_ready) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    // Abort beats both the step sequence and a coincident res_ready.
    if (abort && busy) state_d = ST_IDLE;
  end

  // NOTE: every output gets a default before the case so no path through
  // this block leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state     = state_q;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    mux_en    = 1'b0;
    nib_a     = '0;
    nib_b     = '0;
    shift_sel = SH_0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_COMPUTE_1: begin
        mux_en    = 1'b1;
        nib_a     = a_q[NIB_W-1:0];
        nib_b     = b_q[NIB_W-1:0];
        shift_sel = SHIFT_C1;
      end
      ST_COMPUTE_2: begin
        mux_en    = 1'b1;
        nib_a     = a_q[OP_W-1:NIB_W];
        nib_b     = b_q[NIB_W-1:0];
        shift_sel = SHIFT_C2;
      end
      ST_COMPUTE_3: begin
        mux_en    = 1'b1;
        nib_a     = a_q[NIB_W-1:0];
        nib_b     = b_q[OP_W-1:NIB_W];
        shift_sel = SHIFT_C3;
      end
      ST_COMPUTE_4: begin
        mux_en    = 1'b1;
        nib_a     = a_q[OP_W-1:NIB_W];
        nib_b     = b_q[OP_W-1:NIB_W];
        shift_sel = SHIFT_C4;
      end
      ST_DONE: res_valid = 1'b1;
      // Corrupted code: look like IDLE but hold off acceptance for the one
      // cycle before the register recovers, so no operand pair is dropped.
      default: state = ST_IDLE;
    endcase
  end

  hex_mul_acc u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (acc_clr),
    .add_en    (mux_en),
    .shift_sel (shift_sel),
    .pp        (pp_in),
    .acc       (acc)
  );

  assign result = acc;

endmodule
